// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a shared 8N1 UART transmitter.
// One byte is latched per frame; each bit advances on a tx_tick strobe.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               clk50,
  input  logic               rst,
  input  logic               tx_tick,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id
);

  typedef enum logic [2:0] {StIdle, StWait, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            tx_q, tx_d;

  logic            any_valid;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;

  // Search last+1, last+2, ... (mod N_REQ); the first valid requester wins.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_q) + k) % N_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && any_valid) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    tx_d       = tx_q;
    case (state_q)
      StIdle: begin
        // A tick in the capture cycle is deliberately not consumed.
        if (any_valid) begin
          shreg_d    = req_data[{win, 3'b000} +: 8];
          last_d     = win;
          grant_id_d = win;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (tx_tick) begin
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tx_tick) begin
          tx_d      = shreg_q[0];
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tx_tick) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d      = shreg_q[bit_cnt_q + 3'd1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tx_tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      grant_id_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      grant_id_q <= grant_id_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 4-cycle tx_tick period.
module tb_uart_tx_arbiter;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        tx_tick = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tick_ph = 0;
  int cnt[4];
  bit auto_drop = 1'b1;
  int pulse_on = -1;
  int pulse_off = -1;

  uart_tx_arbiter #(.N_REQ(4)) dut (
    .clk50    (clk50),
    .rst      (rst),
    .tx_tick  (tx_tick),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log transfers, apply requester behaviour, then drive next tick.
  task automatic step();
    logic [3:0] x;
    #1;
    x = req_valid & req_ready;
    for (int i = 0; i < 4; i++) if (x[i]) cnt[i]++;
    @(posedge clk50);
    #1;
    cyc++;
    if (auto_drop) req_valid = req_valid & ~x;
    if (cyc == pulse_on) req_valid[1] = 1'b1;
    if (cyc == pulse_off) req_valid[1] = 1'b0;
    tick_ph = (tick_ph + 1) % 4;
    tx_tick = (tick_ph == 0);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_low(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk({tag, " start_seen"}, {31'd0, tx}, 32'd0);
  endtask

  // Checks every cycle of a frame from the first start-bit cycle.
  task automatic recv(input logic [7:0] b, input logic [1:0] gid, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    wait_low(tag);
    for (int k = 1; k < 40; k++) begin
      step();
      chk({tag, " line"}, {31'd0, tx}, {31'd0, fr[k/4]});
    end
    chk({tag, " busy_stop"}, {31'd0, busy}, 32'd1);
    step();
    chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, " grant_id"}, {30'd0, grant_id}, {30'd0, gid});
  endtask

  initial begin
    clr_cnt();
    step();
    step();
    step();
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ready", {28'd0, req_ready}, 32'd0);
    chk("rst grant", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    step();

    // Single byte from requester 0
    clr_cnt();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    #1;
    chk("t1 ready", {28'd0, req_ready}, 32'h1);
    step();
    chk("t1 busy_rise", {31'd0, busy}, 32'd1);
    chk("t1 ready_gone", {28'd0, req_ready}, 32'd0);
    recv(8'hA5, 2'd0, "t1");
    chk("t1 cnt0", cnt[0], 32'd1);
    chk("t1 cnt_other", cnt[1] + cnt[2] + cnt[3], 32'd0);

    // All four valid continuously
    do_reset();
    clr_cnt();
    auto_drop = 1'b0;
    req_data = 32'h13121110;
    req_valid = 4'b1111;
    recv(8'h10, 2'd0, "t2a");
    recv(8'h11, 2'd1, "t2b");
    recv(8'h12, 2'd2, "t2c");
    recv(8'h13, 2'd3, "t2d");
    recv(8'h10, 2'd0, "t2e");
    req_valid = '0;
    chk("t2 cnt0", cnt[0], 32'd2);
    chk("t2 cnt1", cnt[1], 32'd1);
    chk("t2 cnt2", cnt[2], 32'd1);
    chk("t2 cnt3", cnt[3], 32'd1);

    // Fairness between requesters 1 and 3
    do_reset();
    clr_cnt();
    req_data = 32'h23002100;
    req_valid = 4'b1010;
    recv(8'h21, 2'd1, "t3a");
    recv(8'h23, 2'd3, "t3b");
    recv(8'h21, 2'd1, "t3c");
    recv(8'h23, 2'd3, "t3d");
    req_valid = '0;
    chk("t3 cnt1", cnt[1], 32'd2);
    chk("t3 cnt3", cnt[3], 32'd2);

    // Reset during d4, after d3 has been sent
    clr_cnt();
    auto_drop = 1'b1;
    req_data = 32'h0000003C;
    req_valid = 4'b0001;
    wait_low("t4");
    for (int i = 0; i < 21; i++) step();
    chk("t4 busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("t4 tx", {31'd0, tx}, 32'd1);
    chk("t4 busy", {31'd0, busy}, 32'd0);
    chk("t4 ready", {28'd0, req_ready}, 32'd0);
    chk("t4 grant", {30'd0, grant_id}, 32'd0);
    rst = 1'b0;
    req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    #1;
    chk("t4 ready2", {28'd0, req_ready}, 32'h4);
    recv(8'h5A, 2'd2, "t4");
    chk("t4 cnt0", cnt[0], 32'd1);
    chk("t4 cnt2", cnt[2], 32'd1);

    // Idle ticks, then a tick landing in the capture cycle
    clr_cnt();
    for (int i = 0; i < 8 && !(i > 0 && tx_tick); i++) begin
      step();
      chk("t5 idle_tx", {31'd0, tx}, 32'd1);
      chk("t5 idle_ready", {28'd0, req_ready}, 32'd0);
    end
    chk("t5 tick_now", {31'd0, tx_tick}, 32'd1);
    req_data[7:0] = 8'h96;
    req_valid = 4'b0001;
    #1;
    chk("t5 ready", {28'd0, req_ready}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5 hold", {31'd0, tx}, 32'd1);
    end
    step();
    chk("t5 start", {31'd0, tx}, 32'd0);
    recv(8'h96, 2'd0, "t5");

    // Requester 1 raises then withdraws valid during a frame owned by 0
    clr_cnt();
    req_data = 32'h0000EE77;
    req_valid = 4'b0001;
    pulse_on = cyc + 10;
    pulse_off = cyc + 20;
    recv(8'h77, 2'd0, "t6");
    for (int i = 0; i < 50; i++) begin
      step();
      chk("t6 quiet_tx", {31'd0, tx}, 32'd1);
    end
    chk("t6 busy", {31'd0, busy}, 32'd0);
    chk("t6 cnt0", cnt[0], 32'd1);
    chk("t6 cnt1", cnt[1], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmit line among `N_REQ` byte-producing clients. It runs round-robin arbitration over valid/ready byte requests and latches the winner's byte. It then serializes that byte (start, 8 data LSB-first, stop), advancing one bit per `tx_tick` strobe from the baud-rate generator's TX tick output. The block sits between on-chip byte sources (debug console, status reporter, loopback) and the `tx` pin.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `ID_W`, `$clog2(N_REQ)`: width of `grant_id`.

Ports:
- `clk50` input 1: 50 MHz system clock; all logic on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `tx_tick` input 1: one-`clk50`-cycle baud strobe, nominally every 434 cycles (115200 baud).
- `req_valid` input `N_REQ`: bit i = requester i has a byte.
- `req_data` input `8*N_REQ`: byte i in bits [8i+7:8i].
- `req_ready` output `N_REQ`: one-hot; a byte is transferred in any cycle where `req_valid[i] & req_ready[i]`.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high whenever the state is not IDLE.
- `grant_id` output `ID_W`: index of the last granted requester.

## Operation
- States are IDLE, WAIT, START, DATA and STOP. The registers are `state`, `shreg[7:0]`, `bit_cnt[2:0]`, `last[ID_W-1:0]`, `tx` and `grant_id`.
- **Arbitration**
  - Arbitration is combinational and runs only in IDLE.
  - The search order is `last+1, last+2, …` mod `N_REQ`. The first requester with `valid=1` wins.
  - `req_ready[win]=1` for that cycle only. All other `req_ready` bits stay 0.
  - `req_ready` is 0 in every non-IDLE state, and in IDLE when no valid is present.
- **Capture edge** (IDLE with any valid):
  - `shreg<=req_data[win]`, `last<=win`, `grant_id<=win`, `state<=WAIT`.
- **Per-state action on a `tx_tick` edge** (no `tx_tick` = hold):
  - WAIT: `tx<=0`, go to START.
  - START: `tx<=shreg[0]`, `bit_cnt<=0`, go to DATA.
  - DATA with `bit_cnt<7`: `tx<=shreg[bit_cnt+1]`, `bit_cnt++`.
  - DATA with `bit_cnt==7`: `tx<=1`, go to STOP.
  - STOP: go to IDLE; `tx` stays 1.
- `tx_tick` in IDLE is ignored.
- If `tx_tick` arrives in the capture cycle, it is not consumed. The start bit waits for the next tick.
- Requesters must hold `valid` and `data` stable until ready. A request whose `valid` drops before it is granted is never sent.
- **Reset values:** `state=IDLE`, `tx=1`, `busy=0`, `req_ready=0`, `grant_id=0`, `bit_cnt=0`, `shreg=0`, `last=N_REQ-1`. With `last=N_REQ-1`, the first search starts at requester 0.
- Reset asserted mid-frame aborts the frame. `tx` is 1 on the cycle after the reset edge, and the aborted byte is not retransmitted.
- `rst` overrides any simultaneous request or tick.

## Timing
- **Latency:** a grant occurs in the first IDLE cycle with any valid. The start bit begins on the cycle after the first `tx_tick` observed in WAIT.
- **Bit length:** every bit (start, d0–d7, stop) lasts exactly one tick period, e.g. 434 cycles.
- **Frame length:** a frame spans 10 tick periods on the line. `busy` rises the cycle after capture and falls the cycle after the tick that ends STOP.
- **Back-to-back frames:** the next capture can happen in the first IDLE cycle, i.e. the cycle after STOP exits. The gap between stop-bit end and the next start bit is at most one tick period. `tx` stays 1 throughout the gap.
- **Throughput:** at most one grant per frame. No `req_ready` pulse occurs while `busy` is high.
- `tx` is registered: glitch-free, and changes only on the edge following a `tx_tick` cycle (or on reset).

## Test plan
- **Single byte:** 4-cycle `tx_tick` period, requester 0 sends 0xA5.
  - `req_ready[0]` pulses for exactly 1 cycle.
  - `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles.
  - `grant_id=0`; `busy` covers the frame as specified.
- **All four requesters valid continuously** with bytes 0x10, 0x11, 0x12, 0x13.
  - Frames go out in order 0x10, 0x11, 0x12, 0x13, then 0x10 again.
  - Exactly one `req_ready` pulse occurs per frame.
- **Fairness:** requesters 1 and 3 are always valid.
  - Grants alternate 1, 3, 1, 3.
  - `grant_id` matches each frame.
- **Reset mid-DATA:** pulse `rst` after d3 has been sent.
  - `tx=1` and `busy=0` the next cycle.
  - The next request from requester 2 is granted first among {0, 2}, because the search restarts at 0 and 0 is not valid.
- **Tick in the capture cycle:**
  - `tx` stays 1 until the edge after the following tick.
  - Ticks while IDLE with no valid leave `tx=1` and `req_ready=0`.
- **Valid withdrawn while busy:** requester 1 raises then drops `valid` during a frame owned by 0.
  - Requester 1 never receives `req_ready`.
  - No extra frame is sent.
